// File: rtl/bin_cnt_univ.sv
// bin_cnt_univ: universal up/down binary counter with load, modulo, one-shot and hold modes.
// Define BIN_CNT_DOWN_EN to let `up` select direction; otherwise the counter only counts up.
module bin_cnt_univ #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] lim,
  input  logic [1:0]       mode,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);
  logic [WIDTH-1:0] q_q, q_d, inc, dec, lm1;
  logic done_q, done_d, dn, step, zero, oor, stop, wrap;
`ifdef BIN_CNT_DOWN_EN
  assign dn = ~up;
`else
  assign dn = up & 1'b0;
`endif
  assign inc  = q_q + WIDTH'(1);
  assign dec  = q_q - WIDTH'(1);
  assign lm1  = lim - WIDTH'(1);
  assign zero = q_q == '0;
  // lim=0 means a full 2^WIDTH modulus, so nothing is out of range
  assign oor  = (lim != '0) && (q_q >= lim);
  assign stop = dn ? zero : (q_q >= lim);
  assign step = en & ~load & (mode != 2'b11);
  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    wrap   = 1'b0;
    if (load) begin
      q_d    = d;
      done_d = 1'b0;
    end else if (step) begin
      case (mode)
        2'b00: begin
          wrap = dn ? zero : (q_q == '1);
          q_d  = dn ? dec : inc;
        end
        2'b01: begin
          wrap = dn ? zero : (q_q >= lm1);
          q_d  = dn ? ((zero | oor) ? lm1 : dec) : (wrap ? '0 : inc);
        end
        default: begin
          wrap   = ~stop & (dn ? (q_q == WIDTH'(1)) : (inc == lim));
          q_d    = stop ? q_q : (dn ? dec : inc);
          done_d = done_q | stop | wrap;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end
  assign q    = q_q;
  assign done = done_q;
  assign tc   = step & ~reset & wrap;
endmodule

// File: tb/tb_bin_cnt_univ.sv
// tb_bin_cnt_univ: directed self-checking bench for bin_cnt_univ (WIDTH=8).
module tb_bin_cnt_univ;
  logic       clk = 1'b0;
  logic       reset, en, load, up, tc, done;
  logic [7:0] d, lim, q;
  logic [1:0] mode;
  int n_cmp = 0;
  int n_err = 0;

  bin_cnt_univ #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .lim(lim),
    .mode(mode), .up(up), .q(q), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; load = 1'b0; d = '0; lim = '0; mode = 2'b00; up = 1'b1;
    tick();
    #1;
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL reset_q got=%0d exp=0", q); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b exp=0", tc); end
    reset = 1'b0;
  endtask

  task automatic test_free_run;
    mode = 2'b00; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      n_cmp++; if (q !== 8'(i)) begin n_err++; $display("FAIL free_q i=%0d got=%0d exp=%0d", i, q, i); end
      n_cmp++; if (tc !== (i == 255)) begin n_err++; $display("FAIL free_tc i=%0d got=%b exp=%b", i, tc, i == 255); end
      tick();
    end
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL free_wrap got=%0d exp=0", q); end
  endtask

  task automatic test_load_priority;
    en = 1'b1; load = 1'b1; d = 8'd163;
    #1;
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL load_tc got=%b exp=0", tc); end
    tick();
    load = 1'b0;
    n_cmp++; if (q !== 8'd163) begin n_err++; $display("FAIL load_q got=%0d exp=163", q); end
    tick();
    n_cmp++; if (q !== 8'd164) begin n_err++; $display("FAIL load_next got=%0d exp=164", q); end
  endtask

  task automatic test_modulo;
    mode = 2'b01; lim = 8'd10; up = 1'b1; en = 1'b1; load = 1'b1; d = 8'd0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++; if (q !== 8'(i % 10)) begin n_err++; $display("FAIL mod_q i=%0d got=%0d exp=%0d", i, q, i % 10); end
      n_cmp++; if (tc !== (i % 10 == 9)) begin n_err++; $display("FAIL mod_tc i=%0d got=%b exp=%b", i, tc, i % 10 == 9); end
      tick();
    end
    load = 1'b1; d = 8'd200;
    tick();
    load = 1'b0;
    n_cmp++; if (q !== 8'd200) begin n_err++; $display("FAIL mod_load got=%0d exp=200", q); end
    tick();
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL mod_reenter got=%0d exp=0", q); end
`ifdef BIN_CNT_DOWN_EN
    up = 1'b0;
    #1;
    n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL mod_dn_tc got=%b exp=1", tc); end
    tick();
    n_cmp++; if (q !== 8'd9) begin n_err++; $display("FAIL mod_dn_wrap got=%0d exp=9", q); end
    tick();
    n_cmp++; if (q !== 8'd8) begin n_err++; $display("FAIL mod_dn_step got=%0d exp=8", q); end
    up = 1'b1;
`endif
  endtask

  task automatic test_one_shot;
    mode = 2'b10; lim = 8'd5; load = 1'b1; d = 8'd0; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (q !== 8'(i)) begin n_err++; $display("FAIL os_q i=%0d got=%0d exp=%0d", i, q, i); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL os_done_early i=%0d got=%b exp=0", i, done); end
      n_cmp++; if (tc !== (i == 4)) begin n_err++; $display("FAIL os_tc i=%0d got=%b exp=%b", i, tc, i == 4); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (q !== 8'd5) begin n_err++; $display("FAIL os_hold_q i=%0d got=%0d exp=5", i, q); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL os_done i=%0d got=%b exp=1", i, done); end
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL os_hold_tc i=%0d got=%b exp=0", i, tc); end
      tick();
    end
    load = 1'b1; d = 8'd2;
    tick();
    load = 1'b0;
    n_cmp++; if (q !== 8'd2) begin n_err++; $display("FAIL os_reload_q got=%0d exp=2", q); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL os_reload_done got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid;
    mode = 2'b10; lim = 8'd5; load = 1'b1; d = 8'd0; en = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    n_cmp++; if (q !== 8'd3) begin n_err++; $display("FAIL mid_pre got=%0d exp=3", q); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL mid_q got=%0d exp=0", q); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got=%b exp=0", done); end
    tick();
    n_cmp++; if (q !== 8'd1) begin n_err++; $display("FAIL mid_resume got=%0d exp=1", q); end
  endtask

  task automatic test_hold;
    mode = 2'b10; lim = 8'd78; load = 1'b1; d = 8'd77; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (q !== 8'd77) begin n_err++; $display("FAIL hold_en_q i=%0d got=%0d exp=77", i, q); end
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL hold_en_tc i=%0d got=%b exp=0", i, tc); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL hold_en_done i=%0d got=%b exp=0", i, done); end
      tick();
    end
    en = 1'b1; mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (q !== 8'd77) begin n_err++; $display("FAIL hold_md_q i=%0d got=%0d exp=77", i, q); end
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL hold_md_tc i=%0d got=%b exp=0", i, tc); end
      tick();
    end
    mode = 2'b10;
    #1;
    n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL hold_os_tc got=%b exp=1", tc); end
    tick();
    n_cmp++; if (q !== 8'd78 || done !== 1'b1) begin n_err++; $display("FAIL hold_os_done q=%0d done=%b exp q=78 done=1", q, done); end
    mode = 2'b11;
    repeat (10) tick();
    n_cmp++; if (q !== 8'd78 || done !== 1'b1) begin n_err++; $display("FAIL hold_keep_done q=%0d done=%b exp q=78 done=1", q, done); end
    mode = 2'b00;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mode_keep_done got=%b exp=1", done); end
    n_cmp++; if (q !== 8'd79) begin n_err++; $display("FAIL mode_free_q got=%0d exp=79", q); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_priority();
    test_modulo();
    test_one_shot();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bin_cnt_univ.md
# bin_cnt_univ

Parametrised universal binary counter: the next-generation replacement for the fixed 8-bit free-running counter in the binary_counter family. Adds configurable width, synchronous parallel load, count enable, free-run / modulo / one-shot / hold modes, an optional down-count direction and terminal-count flags. It is used as the timebase and event counter for the seminar's timer, divider and sequencer exercises.

## Interface

- WIDTH, 8, counter width in bits (2..32).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; the counter advances only when 1.
- load  input  1  synchronous parallel load of `d`.
- d  input  WIDTH  load value.
- lim  input  WIDTH  modulus / terminal value for modulo and one-shot modes.
- mode  input  2  00 free-run, 01 modulo, 10 one-shot, 11 hold.
- up  input  1  direction, 1 = up, 0 = down (see Configuration).
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal-count tick: 1 when en=1, load=0, reset=0 and the next edge wraps or stops.
- done  output  1  registered one-shot completion flag.

## Operation

- Priority per edge: reset > load > en > hold.
- reset: q <= 0, done <= 0.
- load: q <= d, done <= 0. Count enable is ignored in the load cycle.
- en=0 or mode=11: q and done hold.
- Free-run (00): up q <= q+1 mod 2^WIDTH; down q <= q-1 mod 2^WIDTH. tc when q is all-ones (up) or 0 (down).
- Modulo (01), range 0..lim-1:
  - up: q <= (q >= lim-1) ? 0 : q+1. tc when q >= lim-1.
  - down: q <= (q == 0 or q >= lim) ? lim-1 : q-1. tc when q == 0.
  - lim=0 means modulus 2^WIDTH (identical to free-run).
  - Out-of-range loaded values (q >= lim) are re-entered on the next enabled edge as above, never counted through.
- One-shot (10):
  - up: counts toward lim. On the edge where q becomes lim, done <= 1. Once q >= lim, q holds and done is 1.
  - down: counts toward 0. On the edge where q becomes 0, done <= 1. Once q == 0, q holds.
  - tc when the next enabled edge reaches the stop value.
  - done stays 1 until load or reset. Changing mode does not clear it.
- Mode and lim changes take effect on the next edge. No internal state besides q and done.
- Arithmetic is performed in WIDTH bits. No carry out beyond tc.

## Timing

- q and done are registered. Each changes one clk edge after the qualifying inputs are sampled.
- Load latency is 1 cycle. The count value is visible one cycle after the enabled edge.
- tc is combinational from q, en, mode, up, lim, load and reset, with no register stage. It is valid in the same cycle as the condition, so a downstream `en` can cascade counters with zero-cycle carry.
- Reset values: q = 0, done = 0, so tc = 0 (tc is gated by reset).
- Reset asserted mid-count or mid-one-shot aborts on that edge. There is no pending state.
- Simultaneous load and en: load wins, and tc = 0 that cycle.

## Configuration

- BIN_CNT_DOWN_EN defined: the `up` input selects direction as described above.
- BIN_CNT_DOWN_EN undefined: the `up` port remains in the interface but is ignored and treated as 1. All down-count logic is removed, and every mode counts up only.

## Test plan

- Free-run wrap, WIDTH=8: reset, then en=1 for 256 cycles. Required: q goes 0..255, tc=1 only at q=255, and q=0 after the 256th edge.
- Load priority: hold en=1, then pulse load with d=163 in the same cycle. Required: q=163 next cycle, tc=0 during the load cycle, and q=164 one edge later.
- Modulo 10, up and down: mode=01, lim=10. Up: q cycles 0..9 then 0, with tc at q=9. Load d=200: q=0 next enabled edge. Down (macro on): from q=0, the next value is 9.
- One-shot: mode=10, lim=5, load d=0, en=1. Required: q reaches 5 after 5 edges, done=1 on that edge, and q holds at 5 with en still 1. A subsequent load with d=2 gives done=0 and q=2.
- Reset mid-operation: during a one-shot with q=3, assert reset for 1 cycle. Required: q=0 and done=0 next edge, and counting resumes from 0 after reset is released.
- Enable and hold: en=0 or mode=11 for 10 cycles at q=77. Required: q stays 77, tc=0, and done is unchanged.
